// File: rtl/mdu_multicycle.sv
// mdu_multicycle -- multi-cycle multiply/divide unit with architectural HI/LO
// registers, sitting in the EX stage of the pipelined MIPS core.
//
// One operation is accepted per start pulse while the unit is idle. Multiply
// and divide class ops hold busy for MUL_CYCLES / DIV_CYCLES cycles and only
// then write HI/LO, pulsing done for one cycle. MTHI/MTLO complete on the
// accept edge with no busy and no done. The hazard unit stalls younger HI/LO
// consumers on start|busy.
//
// Optional feature macro: MDU_MADD_EN
//   defined   -> MADD (110) / MSUB (111) accumulate a signed product into
//                {hi,lo} with MUL_CYCLES latency.
//   undefined -> 110/111 are ignored and no accumulate datapath is built.
//
// Parameters:
//   WIDTH       operand and HI/LO width (>= 2)
//   MUL_CYCLES  busy cycles for multiply-class ops (>= 1)
//   DIV_CYCLES  busy cycles for divide-class ops (>= 1)
//
// Ports:
//   clk     clock, rising edge
//   reset   synchronous active-high reset
//   start   request strobe, sampled every rising edge
//   op      3-bit operation code
//   src_a   rs operand
//   src_b   rt operand
//   busy    an operation is in flight
//   done    one-cycle pulse after HI/LO were updated by a multi-cycle op
//   hi, lo  architectural HI/LO registers

module mdu_multicycle #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, done_d;

  logic               accept_multi;
  logic               mt_hi_wr;
  logic               mt_lo_wr;
  logic               finish;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe;
  logic [WIDTH-1:0]   q_mag, r_mag, quot, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_wr;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_add, acc_sub;
`endif

  // State register and down-counter that times the busy window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. In IDLE a start either launches a multi-cycle op or
  // performs an immediate HI/LO move; in RUN every start is ignored and the
  // counter runs down, finishing on the edge where it reads 1.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_multi = 1'b0;
    mt_hi_wr     = 1'b0;
    mt_lo_wr     = 1'b0;
    finish       = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              accept_multi = 1'b1;
              cnt_d        = CNT_MUL;
            end
            OP_DIV, OP_DIVU: begin
              accept_multi = 1'b1;
              cnt_d        = CNT_DIV;
            end
            OP_MTHI: mt_hi_wr = 1'b1;
            OP_MTLO: mt_lo_wr = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: begin
              accept_multi = 1'b1;
              cnt_d        = CNT_MUL;
            end
`endif
            default: ;
          endcase
          if (accept_multi) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          finish  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result datapath evaluated from the latched operands. Division works on
  // magnitudes and re-applies signs so the quotient truncates toward zero
  // and the remainder follows the dividend; most-negative / -1 falls out as
  // quotient = most-negative, remainder = 0. A zero divisor is replaced by 1
  // only to keep the divider well defined; its result is never written.
  always_comb begin
    prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    a_neg  = (op_q == OP_DIV) && a_q[WIDTH-1];
    b_neg  = (op_q == OP_DIV) && b_q[WIDTH-1];
    a_mag  = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag  = b_neg ? (~b_q + 1'b1) : b_q;
    b_safe = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem    = a_neg ? (~r_mag + 1'b1) : r_mag;

`ifdef MDU_MADD_EN
    acc_add = {hi_q, lo_q} + prod_s;
    acc_sub = {hi_q, lo_q} - prod_s;
`endif

    res_hi = hi_q;
    res_lo = lo_q;
    res_wr = 1'b0;
    case (op_q)
      OP_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_wr           = 1'b1;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_wr           = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        if (b_q != '0) begin
          res_hi = rem;
          res_lo = quot;
          res_wr = 1'b1;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        {res_hi, res_lo} = acc_add;
        res_wr           = 1'b1;
      end
      OP_MSUB: begin
        {res_hi, res_lo} = acc_sub;
        res_wr           = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Operand latches, HI/LO and the done pulse. HI/LO change only on an
  // immediate move or on the finishing edge of a multi-cycle op.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (accept_multi) begin
        op_q <= op;
        a_q  <= src_a;
        b_q  <= src_b;
      end
      if (mt_hi_wr) begin
        hi_q <= src_a;
      end
      if (mt_lo_wr) begin
        lo_q <= src_a;
      end
      if (finish && res_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_multicycle.sv
// tb_mdu_multicycle -- self-checking bench for mdu_multicycle with the
// default parameters (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10). A table of
// directed vectors with hand-derived results is followed by multi-cycle
// corner sequences and randomized ops checked against a plain-arithmetic
// model of HI/LO. Honours MDU_MADD_EN the same way the design does.

module tb_mdu_multicycle;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  logic [31:0] mhi;
  logic [31:0] mlo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  mdu_multicycle #(
    .WIDTH(32),
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .src_a(src_a),
    .src_b(src_b),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive a request on the falling edge so it is stable at the next rising edge.
  task automatic applyStimulus(input logic s, input logic [2:0] o,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = s;
    op    = o;
    src_a = a;
    src_b = b;
  endtask

  // Reference model: HI/LO as plain 64-bit arithmetic; returns the busy length.
  task automatic modelStep(input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, output int cyc);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    cyc = 0;
    case (o)
      3'd0: begin
        p = 64'(sa * sb);
        {mhi, mlo} = p;
        cyc = 5;
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        {mhi, mlo} = p;
        cyc = 5;
      end
      3'd2: begin
        cyc = 10;
        if (b != 0) begin
          q   = sa / sb;
          r   = sa % sb;
          mlo = 32'(q);
          mhi = 32'(r);
        end
      end
      3'd3: begin
        cyc = 10;
        if (b != 0) begin
          mlo = a / b;
          mhi = a % b;
        end
      end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: begin
`ifdef MDU_MADD_EN
        p = 64'(sa * sb);
        if (o == 3'd6) {mhi, mlo} = {mhi, mlo} + p;
        else           {mhi, mlo} = {mhi, mlo} - p;
        cyc = 5;
`endif
      end
    endcase
  endtask

  // Issue one op and follow it to completion, checking busy length, HI/LO
  // stability during RUN, the done pulse and the final HI/LO.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_cyc,
                       input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt;
    applyStimulus(1'b1, o, a, b);
    tick();
    start = 1'b0;
    if (exp_cyc == 0) begin
      checkOutput("imm_busy", {31'b0, busy}, 32'd0);
      checkOutput("imm_done", {31'b0, done}, 32'd0);
      checkOutput("imm_hi", hi, exp_hi);
      checkOutput("imm_lo", lo, exp_lo);
    end else begin
      cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
        cnt++;
        checkOutput("run_hi_hold", hi, prev_hi);
        checkOutput("run_lo_hold", lo, prev_lo);
        tick();
      end
      checkOutput("busy_cycles", cnt, exp_cyc);
      checkOutput("done_pulse", {31'b0, done}, 32'd1);
      checkOutput("res_hi", hi, exp_hi);
      checkOutput("res_lo", lo, exp_lo);
      tick();
      checkOutput("done_clear", {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    int          cyc;
    int          cnt;
    logic        saw_done;
    logic [31:0] ph, pl, ra, rb;
    logic [2:0]  ro;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd0;
    src_a  = '0;
    src_b  = '0;
    mhi    = '0;
    mlo    = '0;

    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{3'd3, 32'd5,         32'd0,        10, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd4, 32'h0000_1234, 32'd0,        0,  32'h0000_1234, 32'h8000_0000};
    vecs[6] = '{3'd5, 32'h0000_5678, 32'd0,        0,  32'h0000_1234, 32'h0000_5678};
`ifdef MDU_MADD_EN
    vecs[7] = '{3'd6, 32'd2,         32'd3,        5,  32'h0000_1234, 32'h0000_567E};
`else
    vecs[7] = '{3'd6, 32'd2,         32'd3,        0,  32'h0000_1234, 32'h0000_5678};
`endif

    repeat (2) tick();
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    reset = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc, mhi, mlo,
            vecs[i].hi, vecs[i].lo);
      mhi = vecs[i].hi;
      mlo = vecs[i].lo;
    end

    $display("[TB] start during RUN is ignored");
    ph = mhi;
    pl = mlo;
    applyStimulus(1'b1, 3'd2, 32'd100, 32'd7);
    tick();
    start = 1'b0;
    cnt = 1;
    repeat (2) begin
      tick();
      if (busy === 1'b1) cnt++;
    end
    start = 1'b1;
    op    = 3'd0;
    src_a = 32'd5;
    src_b = 32'd5;
    while (cnt < 200) begin
      tick();
      start = 1'b0;
      if (busy !== 1'b1) break;
      cnt++;
    end
    checkOutput("ign_cycles", cnt, 32'd10);
    checkOutput("ign_done", {31'b0, done}, 32'd1);
    checkOutput("ign_hi", hi, 32'd2);
    checkOutput("ign_lo", lo, 32'd14);
    mhi = 32'd2;
    mlo = 32'd14;
    tick();
    checkOutput("ign_no_mult", {31'b0, busy}, 32'd0);
    checkOutput("ign_done_clear", {31'b0, done}, 32'd0);

    $display("[TB] reset during RUN");
    applyStimulus(1'b1, 3'd2, 32'd50, 32'd3);
    tick();
    start = 1'b0;
    repeat (5) tick();
    checkOutput("abort_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checkOutput("abort_quiet", {31'b0, saw_done}, 32'd0);
    mhi = '0;
    mlo = '0;

    $display("[TB] randomized ops");
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'd0;
        1:       ra = 32'h8000_0000;
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      ph = mhi;
      pl = mlo;
      modelStep(ro, ra, rb, cyc);
      runOp(ro, ra, rb, cyc, ph, pl, mhi, mlo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
